// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: operation encodings, controller states,
// flag bundle and the default operand width.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOR  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } opsel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic c;
        logic z;
        logic o;
        logic s;
    } flags_t;

    // ADD and SUB are the only operations that use the carry chain.
    function automatic logic is_arith(opsel_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// One-bit ALU datapath: full adder for ADD/SUB (operand b inverted for SUB)
// and bitwise logic functions; reserved encodings produce zero.
module alu_slice
    import alu_pkg::*;
(
    input  logic   a,
    input  logic   b,
    input  logic   cin,
    input  opsel_e opsel,
    output logic   res,
    output logic   cout
);

    logic b_eff;

    always_comb begin
        res   = 1'b0;
        cout  = 1'b0;
        b_eff = b;
        case (opsel)
            OP_ADD, OP_SUB: begin
                b_eff = (opsel == OP_SUB) ? ~b : b;
                res   = a ^ b_eff ^ cin;
                cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: accepts an operation in IDLE, feeds one operand
// bit per RUN cycle through alu_slice, then holds result and flags in DONE.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       opsel,
    input  logic             mode,
    output logic             ready,
    output logic             valid,
    input  logic             ack,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag,
    output logic             o_flag,
    output logic             s_flag
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    opsel_e           op_q,     op_d;
    logic             mode_q,   mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q,  flags_d;
    logic             ready_q,  ready_d;
    logic             valid_q,  valid_d;

    logic             slice_res;
    logic             slice_cout;
    logic [WIDTH-1:0] res_full;
    logic             c_final;

    alu_slice u_slice (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q),
        .opsel (op_q),
        .res   (slice_res),
        .cout  (slice_cout)
    );

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            mode_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state, shift and flag logic.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mode_d   = mode_q;
        result_d = result_q;
        flags_d  = flags_q;
        res_full = {slice_res, res_sh_q};
        c_final  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    a_sh_d   = op_a;
                    b_sh_d   = op_b;
                    op_d     = opsel_e'(opsel);
                    mode_d   = mode;
                    carry_d  = (opsel_e'(opsel) == OP_SUB);
                    cnt_d    = '0;
                    res_sh_d = '0;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_full[WIDTH-1:1];
                carry_d  = slice_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // MSB slice: carry_q is the carry into the MSB.
                    if (op_q == OP_ADD) begin
                        c_final = slice_cout;
                    end else if (op_q == OP_SUB) begin
                        c_final = ~slice_cout;
                    end
                    state_d   = ST_DONE;
                    result_d  = res_full;
                    flags_d.c = c_final;
                    flags_d.z = (res_full == '0);
                    flags_d.s = slice_res;
                    flags_d.o = is_arith(op_q)
                              ? (mode_q ? (carry_q ^ slice_cout) : c_final)
                              : 1'b0;
                    cnt_d     = '0;
                    carry_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    assign ready  = ready_q;
    assign valid  = valid_q;
    assign result = result_q;
    assign c_flag = flags_q.c;
    assign z_flag = flags_q.z;
    assign o_flag = flags_q.o;
    assign s_flag = flags_q.s;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl: driver pushes model predictions,
// monitor pops and compares whenever valid rises.
module tb_alu_serial_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [2:0]   opsel = '0;
    logic         mode = 1'b0;
    logic         ready;
    logic         valid;
    logic         ack = 1'b0;
    logic [W-1:0] result;
    logic         c_flag, z_flag, o_flag, s_flag;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .opsel  (opsel),
        .mode   (mode),
        .ready  (ready),
        .valid  (valid),
        .ack    (ack),
        .result (result),
        .c_flag (c_flag),
        .z_flag (z_flag),
        .o_flag (o_flag),
        .s_flag (s_flag)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c, z, o, s;
        int           acc_edge;
        string        tag;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] last_res = '0;
    logic [3:0]   last_flg = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on whole words.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op, input logic md);
        exp_t e;
        logic [W:0] wide;
        wide = '0;
        e.res = '0;
        e.c = 1'b0;
        e.o = 1'b0;
        case (op)
            3'd0: begin
                wide  = {1'b0, a} + {1'b0, b};
                e.res = wide[W-1:0];
                e.c   = wide[W];
                e.o   = md ? ((a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1])) : e.c;
            end
            3'd1: begin
                e.res = a - b;
                e.c   = (a < b);
                e.o   = md ? ((a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1])) : e.c;
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: e.res = ~(a | b);
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        e.s = e.res[W-1];
        e.acc_edge = 0;
        e.tag = "";
        return e;
    endfunction

    // Monitor: compare on valid rising, check stability and hold otherwise.
    initial begin : monitor
        logic pv;
        exp_t e;
        logic [W-1:0] held_res;
        logic [3:0]   held_flg;
        pv = 1'b0;
        held_res = '0;
        held_flg = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            if (valid && !pv) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_valid", 32'(valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.tag, ".result"},  32'(result), 32'(e.res));
                    chk({e.tag, ".c_flag"},  32'(c_flag), 32'(e.c));
                    chk({e.tag, ".z_flag"},  32'(z_flag), 32'(e.z));
                    chk({e.tag, ".o_flag"},  32'(o_flag), 32'(e.o));
                    chk({e.tag, ".s_flag"},  32'(s_flag), 32'(e.s));
                    chk({e.tag, ".latency"}, 32'(cyc),    32'(e.acc_edge + int'(W)));
                    chk({e.tag, ".ready_lo"}, 32'(ready), 32'd0);
                end
                held_res = result;
                held_flg = {c_flag, z_flag, o_flag, s_flag};
                last_res = result;
                last_flg = held_flg;
            end else if (valid) begin
                chk("done_result_stable", 32'(result), 32'(held_res));
                chk("done_flags_stable", 32'({c_flag, z_flag, o_flag, s_flag}), 32'(held_flg));
            end else begin
                chk("hold_result", 32'(result), 32'(last_res));
                chk("hold_flags", 32'({c_flag, z_flag, o_flag, s_flag}), 32'(last_flg));
            end
            pv = valid;
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ready) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    // Issue one operation; optional noise on start/ack and operands while busy.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic md, input string tag, input bit noise, input int hold,
                         input bit start_with_ack);
        bit ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        op_a = a; op_b = b; opsel = op; mode = md; start = 1'b1;
        e = model(a, b, op, md);
        e.acc_edge = cyc + 1;
        e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < int'(W) + 4; i++) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            op_a = W'($urandom); op_b = W'($urandom);
            opsel = 3'($urandom); mode = 1'($urandom);
            start = noise ? 1'($urandom) : 1'b0;
            ack   = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        ack = 1'b0;
        if (!ok) begin
            chk({tag, ".valid_timeout"}, 32'(valid), 32'd1);
            sb_q.delete();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            start = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        chk({tag, ".valid_held"}, 32'(valid), 32'd1);
        ack = 1'b1;
        start = start_with_ack;
        op_a = W'($urandom); op_b = W'($urandom);
        @(negedge clk);
        ack = 1'b0;
        start = 1'b0;
        chk({tag, ".ready_after_ack"}, 32'(ready), 32'd1);
        chk({tag, ".valid_after_ack"}, 32'(valid), 32'd0);
    endtask

    task automatic reset_mid_run();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        op_a = 8'h12; op_b = 8'h34; opsel = 3'd0; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        last_res = '0;
        last_flg = '0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_run.ready",  32'(ready),  32'd1);
        chk("rst_run.valid",  32'(valid),  32'd0);
        chk("rst_run.result", 32'(result), 32'd0);
        chk("rst_run.flags",  32'({c_flag, z_flag, o_flag, s_flag}), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        // Reset with start held high: nothing may be accepted.
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.ready",  32'(ready),  32'd1);
        chk("reset.valid",  32'(valid),  32'd0);
        chk("reset.result", 32'(result), 32'd0);
        chk("reset.flags",  32'({c_flag, z_flag, o_flag, s_flag}), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset.ready", 32'(ready), 32'd1);
        chk("post_reset.valid", 32'(valid), 32'd0);

        issue(8'h7F, 8'h01, 3'd0, 1'b1, "add_7f_01_s", 1'b0, 1, 1'b0);
        issue(8'hFF, 8'h01, 3'd0, 1'b1, "add_ff_01_s", 1'b0, 0, 1'b0);
        issue(8'hFF, 8'h01, 3'd0, 1'b0, "add_ff_01_u", 1'b0, 2, 1'b0);
        issue(8'h00, 8'h01, 3'd1, 1'b0, "sub_00_01_u", 1'b0, 0, 1'b0);
        issue(8'h05, 8'h05, 3'd1, 1'b0, "sub_05_05_u", 1'b0, 1, 1'b0);
        issue(8'h80, 8'h01, 3'd1, 1'b1, "sub_80_01_s", 1'b0, 0, 1'b0);
        reset_mid_run();
        issue(8'h03, 8'h04, 3'd0, 1'b0, "add_03_04", 1'b0, 0, 1'b0);
        issue(8'hAA, 8'hAA, 3'd4, 1'b1, "xor_aa_aa", 1'b0, 0, 1'b0);
        issue(8'h5C, 8'hE3, 3'd7, 1'b1, "rsv_111", 1'b0, 0, 1'b0);
        issue(8'h5C, 8'hE3, 3'd6, 1'b0, "rsv_110", 1'b0, 0, 1'b0);
        issue(8'hF0, 8'h0F, 3'd5, 1'b0, "nor_f0_0f", 1'b0, 0, 1'b0);
        issue(8'h12, 8'h34, 3'd0, 1'b0, "noisy_ack_start", 1'b1, 2, 1'b1);
        issue(8'h9C, 8'h63, 3'd2, 1'b0, "after_ack_start", 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            issue(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom),
                  $sformatf("rand%0d", n), 1'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  request; accepted only when start=1 and ready=1 on the same edge.
REQ-005 op_a, op_b  in  WIDTH  operands; sampled on the accept edge only.
REQ-006 opsel  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR, 110/111 reserved.
REQ-007 mode  in  1  0 = unsigned, 1 = signed interpretation for o_flag.
REQ-008 ready  out  1  high only in IDLE.
REQ-009 valid  out  1  high only in DONE; result and flags are stable while high.
REQ-010 ack  in  1  consumer acknowledge; effective only when valid=1.
REQ-011 result  out  WIDTH  registered result.
REQ-012 c_flag, z_flag, o_flag, s_flag  out  1 each  registered carry, zero, overflow and sign flags.

Function
REQ-013 FSM states: IDLE, RUN, DONE; IDLE -> RUN on accept; RUN -> DONE after WIDTH bit-cycles; DONE -> IDLE on ack.
REQ-014 Bit-serial operation: one bit per RUN cycle, LSB first, through a single 1-bit slice, with carry held in a register between cycles.
REQ-015 Timing: accept at edge 0; bits 0..WIDTH-1 processed at edges 1..WIDTH; valid=1 from edge WIDTH onward; ready=1 the cycle after ack is sampled.
REQ-016 ADD: carry-in 0; SUB: op_b bits inverted and carry-in 1; result is modulo 2^WIDTH.
REQ-017 c_flag: carry-out for ADD, borrow (= NOT carry-out) for SUB, 0 for logic ops.
REQ-018 z_flag = (result == 0); s_flag = result[WIDTH-1]; both valid for all ops.
REQ-019 o_flag for ADD/SUB: if mode=1, carry into MSB XOR carry out of MSB; if mode=0, equal to c_flag. o_flag = 0 for logic ops.
REQ-020 Reserved opsel: result 0, z_flag 1, other flags 0; same latency as other ops.
REQ-021 start while ready=0 is ignored, including start in the same cycle as ack.
REQ-022 ack while valid=0 is ignored.
REQ-023 result and flags hold their last values until the next operation completes; they are not updated during RUN.
REQ-024 Operand or opsel changes after the accept edge have no effect on the operation in flight.

Reset
REQ-025 rst_n sampled low at any edge, including mid-RUN or in DONE: state -> IDLE, ready=1, valid=0, result=0, all flags 0, carry and bit counter 0; the in-flight operation is discarded.
REQ-026 While rst_n=0, start is not accepted.

Structure
REQ-027 Shared package alu_pkg holds the opsel enum (encodings per REQ-006), the FSM state enum and the default WIDTH constant.
REQ-028 A single sub-module alu_slice (inputs a, b, cin, opsel; outputs res, cout) implements the 1-bit datapath and is instantiated once.
REQ-029 Shift registers for operands and result, plus the bit counter (clog2(WIDTH) bits), reside in alu_serial_ctrl.

Verification (WIDTH=8)
REQ-030 ADD 0x7F+0x01, mode=1 -> result 0x80, c=0, z=0, o=1, s=1; valid rises exactly 8 edges after accept.
REQ-031 ADD 0xFF+0x01, mode=1 -> result 0x00, c=1, z=1, o=0, s=0; repeat with mode=0 -> o=1.
REQ-032 SUB 0x00-0x01, mode=0 -> result 0xFF, c=1, o=1, s=1; SUB 0x05-0x05 -> result 0x00, z=1, c=0.
REQ-033 rst_n low at edge 4 of RUN -> next cycle ready=1, valid=0, result=0x00; a new ADD 0x03+0x04 then yields 0x07.
REQ-034 start pulsed during RUN and in the same cycle as ack -> both ignored; the following start is accepted one cycle after ack.
REQ-035 XOR 0xAA^0xAA -> result 0x00, z=1, c=0, o=0; opsel 111 -> result 0x00, z=1, other flags 0.
